// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decodes the ID instruction into a control word, carries it ID/EX -> EX/MEM -> MEM/WB,
// and raises load-use stall plus jump/branch flushes.
module pipe_ctrl_unit #(
  parameter int ALUOP_W = 3,
  parameter int AW = 5,
  parameter bit LU_HAZ_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5:0]         op_code,
  input  logic [5:0]         func,
  input  logic [AW-1:0]      rs,
  input  logic [AW-1:0]      rt,
  input  logic [AW-1:0]      rd,
  input  logic               br_taken,
  output logic               stall,
  output logic               if_flush,
  output logic               id_flush,
  output logic               illegal,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_bne,
  output logic               ex_lui,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [AW-1:0]      ex_dst,
  output logic               mem_write,
  output logic               mem_read,
  output logic [AW-1:0]      mem_dst,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [AW-1:0]      wb_dst
);
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               branch;
    logic               bne;
    logic               lui;
    logic               mem_write;
    logic               mem_read;
    logic               reg_write;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic [AW-1:0]      dst;
  } ctrl_t;
  ctrl_t dec, id_ex;
  logic [2:0] op3;
  logic jump, legal, rw, br_flush, em_reg_write, em_mem_to_reg;
  always_comb begin
    dec = '0;
    op3 = 3'd0;
    jump = 1'b0;
    legal = 1'b1;
    rw = 1'b0;
    case (op_code)
      6'd0: begin
        case (func)
          6'd32: op3 = 3'd2;
          6'd34: op3 = 3'd6;
          6'd36: op3 = 3'd0;
          6'd37: op3 = 3'd1;
          6'd39: op3 = 3'd4;
          6'd42: op3 = 3'd7;
          6'd0:  op3 = 3'd3;
          6'd2:  op3 = 3'd5;
          6'd8:  jump = 1'b1;
          default: legal = 1'b0;
        endcase
        dec.reg_dst = legal && !jump;
        dec.mem_to_reg = legal && !jump;
        rw = legal && !jump;
      end
      6'd8:  begin rw = 1'b1; dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; op3 = 3'd2; end
      6'd12: begin rw = 1'b1; dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; op3 = 3'd0; end
      6'd13: begin rw = 1'b1; dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; op3 = 3'd1; end
      6'd10: begin rw = 1'b1; dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; op3 = 3'd7; end
      6'd35: begin rw = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1; op3 = 3'd2; end
      6'd43: begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; op3 = 3'd2; end
      6'd15: begin rw = 1'b1; dec.lui = 1'b1; dec.mem_to_reg = 1'b1; end
      6'd4:  begin dec.branch = 1'b1; op3 = 3'd6; end
      6'd5:  begin dec.branch = 1'b1; dec.bne = 1'b1; op3 = 3'd6; end
      6'd2:  jump = 1'b1;
      default: legal = 1'b0;
    endcase
    dec.alu_op = ALUOP_W'(op3);
    dec.dst = dec.reg_dst ? rd : rt;
    dec.reg_write = rw && (dec.dst != '0);
    if (!legal) dec = '0;
  end
  assign illegal = id_valid && !legal;
  // A resolved branch outranks both the load-use stall and any jump sitting in ID.
  assign br_flush = !rst && id_ex.branch && (br_taken ^ id_ex.bne);
  assign stall = LU_HAZ_EN && !rst && !br_flush && id_valid && id_ex.mem_read &&
                 (id_ex.dst != '0) && (id_ex.dst == rs || id_ex.dst == rt);
  assign if_flush = br_flush || (!rst && id_valid && jump && !stall);
  assign id_flush = br_flush;
  always_ff @(posedge clk) begin
    id_ex <= (rst || stall || br_flush || !id_valid) ? '0 : dec;
    mem_write <= rst ? 1'b0 : id_ex.mem_write;
    mem_read <= rst ? 1'b0 : id_ex.mem_read;
    mem_dst <= rst ? '0 : id_ex.dst;
    em_reg_write <= rst ? 1'b0 : id_ex.reg_write;
    em_mem_to_reg <= rst ? 1'b0 : id_ex.mem_to_reg;
    wb_reg_write <= rst ? 1'b0 : em_reg_write;
    wb_mem_to_reg <= rst ? 1'b0 : em_mem_to_reg;
    wb_dst <= rst ? '0 : mem_dst;
  end
  assign ex_reg_dst = id_ex.reg_dst;
  assign ex_alu_src = id_ex.alu_src;
  assign ex_branch = id_ex.branch;
  assign ex_bne = id_ex.bne;
  assign ex_lui = id_ex.lui;
  assign ex_alu_op = id_ex.alu_op;
  assign ex_dst = id_ex.dst;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: decode table plus hazard/flush/reset sequences, scoreboarded through MEM and WB.
module tb_pipe_ctrl_unit;
  typedef struct packed {
    logic rdst, as, br, bne, lui;
    logic [5:0] aop;
    logic mw, mr, rw, mtr;
    logic [4:0] dst;
  } word_t;
  typedef struct packed {
    logic [5:0] o, f;
    logic [4:0] s, t, d;
    logic ill, jf, fl;
    word_t w;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, id_valid = 1'b0, br_taken = 1'b0;
  logic [5:0] op_code = '0, func = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic stall, if_flush, id_flush, illegal, ex_reg_dst, ex_alu_src, ex_branch, ex_bne, ex_lui;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic mem_write, mem_read, wb_reg_write, wb_mem_to_reg;
  logic stall_b, if_flush_b, id_flush_b, illegal_b, ex_reg_dst_b, ex_alu_src_b, ex_branch_b, ex_bne_b, ex_lui_b;
  logic [3:0] ex_alu_op_b;
  logic [4:0] ex_dst_b, mem_dst_b, wb_dst_b;
  logic mem_write_b, mem_read_b, wb_reg_write_b, wb_mem_to_reg_b;
  int checks = 0, errors = 0;
  bit chk_b = 1'b0;
  word_t sb[$];
  vec_t tbl[$];
  word_t z = '0;
  pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .op_code(op_code), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .br_taken(br_taken), .stall(stall), .if_flush(if_flush),
    .id_flush(id_flush), .illegal(illegal), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_lui(ex_lui), .ex_alu_op(ex_alu_op),
    .ex_dst(ex_dst), .mem_write(mem_write), .mem_read(mem_read), .mem_dst(mem_dst),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
  );
  pipe_ctrl_unit #(.ALUOP_W(4), .AW(5), .LU_HAZ_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .op_code(op_code), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .br_taken(br_taken), .stall(stall_b), .if_flush(if_flush_b),
    .id_flush(id_flush_b), .illegal(illegal_b), .ex_reg_dst(ex_reg_dst_b), .ex_alu_src(ex_alu_src_b),
    .ex_branch(ex_branch_b), .ex_bne(ex_bne_b), .ex_lui(ex_lui_b), .ex_alu_op(ex_alu_op_b),
    .ex_dst(ex_dst_b), .mem_write(mem_write_b), .mem_read(mem_read_b), .mem_dst(mem_dst_b),
    .wb_reg_write(wb_reg_write_b), .wb_mem_to_reg(wb_mem_to_reg_b), .wb_dst(wb_dst_b)
  );
  always #5 clk = ~clk;
  function automatic word_t wd(bit rdst, as, br, bne, lui, int aop, bit mw, mr, rw, mtr, int dst);
    return '{rdst, as, br, bne, lui, 6'(aop), mw, mr, rw, mtr, 5'(dst)};
  endfunction
  function automatic vec_t mv(int o, f, s, t, d, bit ill, jf, fl, word_t w);
    return '{6'(o), 6'(f), 5'(s), 5'(t), 5'(d), ill, jf, fl, w};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_flags", {stall, if_flush, id_flush, stall_b, if_flush_b, id_flush_b}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_regs", {ex_reg_dst, ex_alu_src, ex_branch, ex_bne, ex_lui, ex_alu_op, ex_dst,
                     mem_write, mem_read, mem_dst, wb_reg_write, wb_mem_to_reg, wb_dst}, 0);
    chk("rst_regs_b", {ex_reg_dst_b, ex_alu_op_b, ex_dst_b, mem_read_b, mem_dst_b, wb_reg_write_b, wb_dst_b}, 0);
    sb.delete();
    sb.push_back(z);
    sb.push_back(z);
  endtask
  // fl = {stall, if_flush, id_flush, illegal} expected while the instruction sits in ID
  task automatic cyc(input logic v, input logic [5:0] o, f, input logic [4:0] s, t, d,
                     input logic bt, input word_t e, input logic [3:0] fl);
    id_valid = v; op_code = o; func = f; rs = s; rt = t; rd = d; br_taken = bt;
    #2;
    chk("flags", {stall, if_flush, id_flush, illegal}, fl);
    chk("stall_b", stall_b, 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk("ex", {ex_reg_dst, ex_alu_src, ex_branch, ex_bne, ex_lui, 6'(ex_alu_op), ex_dst},
              {e.rdst, e.as, e.br, e.bne, e.lui, e.aop, e.dst});
    if (chk_b)
      chk("ex_b", {ex_reg_dst_b, ex_alu_src_b, ex_branch_b, ex_bne_b, ex_lui_b, 6'(ex_alu_op_b), ex_dst_b},
                  {e.rdst, e.as, e.br, e.bne, e.lui, e.aop, e.dst});
    if (sb.size() >= 3) begin
      chk("mem", {mem_write, mem_read, mem_dst}, {sb[1].mw, sb[1].mr, sb[1].dst});
      chk("wb", {wb_reg_write, wb_mem_to_reg, wb_dst}, {sb[0].rw, sb[0].mtr, sb[0].dst});
      if (chk_b) chk("wb_b", {wb_reg_write_b, wb_mem_to_reg_b, wb_dst_b}, {sb[0].rw, sb[0].mtr, sb[0].dst});
      void'(sb.pop_front());
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, z, 4'b0000);
  endtask
  initial begin
    tbl.push_back(mv(0, 32, 1, 2, 3, 0, 0, 0, wd(1,0,0,0,0,2,0,0,1,1,3)));
    tbl.push_back(mv(0, 34, 1, 2, 7, 0, 0, 0, wd(1,0,0,0,0,6,0,0,1,1,7)));
    tbl.push_back(mv(0, 36, 1, 2, 4, 0, 0, 0, wd(1,0,0,0,0,0,0,0,1,1,4)));
    tbl.push_back(mv(0, 37, 1, 2, 5, 0, 0, 0, wd(1,0,0,0,0,1,0,0,1,1,5)));
    tbl.push_back(mv(0, 39, 1, 2, 6, 0, 0, 0, wd(1,0,0,0,0,4,0,0,1,1,6)));
    tbl.push_back(mv(0, 42, 1, 2, 8, 0, 0, 0, wd(1,0,0,0,0,7,0,0,1,1,8)));
    tbl.push_back(mv(0, 0, 1, 2, 9, 0, 0, 0, wd(1,0,0,0,0,3,0,0,1,1,9)));
    tbl.push_back(mv(0, 2, 1, 2, 10, 0, 0, 0, wd(1,0,0,0,0,5,0,0,1,1,10)));
    tbl.push_back(mv(0, 8, 31, 2, 0, 0, 1, 0, wd(0,0,0,0,0,0,0,0,0,0,2)));
    tbl.push_back(mv(8, 0, 1, 11, 0, 0, 0, 0, wd(0,1,0,0,0,2,0,0,1,1,11)));
    tbl.push_back(mv(12, 0, 1, 12, 0, 0, 0, 0, wd(0,1,0,0,0,0,0,0,1,1,12)));
    tbl.push_back(mv(13, 0, 1, 13, 0, 0, 0, 0, wd(0,1,0,0,0,1,0,0,1,1,13)));
    tbl.push_back(mv(10, 0, 1, 14, 0, 0, 0, 0, wd(0,1,0,0,0,7,0,0,1,1,14)));
    tbl.push_back(mv(35, 0, 1, 15, 0, 0, 0, 0, wd(0,1,0,0,0,2,0,1,1,0,15)));
    tbl.push_back(mv(43, 0, 1, 2, 0, 0, 0, 0, wd(0,1,0,0,0,2,1,0,0,0,2)));
    tbl.push_back(mv(15, 0, 0, 16, 0, 0, 0, 0, wd(0,0,0,0,1,0,0,0,1,1,16)));
    tbl.push_back(mv(4, 0, 1, 2, 0, 0, 0, 0, wd(0,0,1,0,0,6,0,0,0,0,2)));
    tbl.push_back(mv(5, 0, 1, 2, 0, 0, 0, 1, wd(0,0,1,1,0,6,0,0,0,0,2)));
    tbl.push_back(mv(2, 0, 0, 0, 0, 0, 1, 0, z));
    tbl.push_back(mv(63, 0, 1, 2, 3, 1, 0, 0, z));
    tbl.push_back(mv(0, 1, 1, 2, 3, 1, 0, 0, z));
    tbl.push_back(mv(8, 0, 1, 0, 0, 0, 0, 0, wd(0,1,0,0,0,2,0,0,0,1,0)));
    tbl.push_back(mv(0, 32, 1, 2, 0, 0, 0, 0, wd(1,0,0,0,0,2,0,0,0,1,0)));
    tbl.push_back(mv(1, 0, 1, 5, 3, 1, 0, 0, z));
    do_reset();
    chk_b = 1'b1;
    // each instruction is followed by an idle slot, where a not-taken bne in EX must flush
    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].o, tbl[i].f, tbl[i].s, tbl[i].t, tbl[i].d, 1'b0, tbl[i].w, {1'b0, tbl[i].jf, 1'b0, tbl[i].ill});
      cyc(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, z, {1'b0, tbl[i].fl, tbl[i].fl, 1'b0});
    end
    idle(3);
    chk_b = 1'b0;
    // load-use: lw r4 then add r5,r4,r2 stalls once, add is re-presented and proceeds
    cyc(1'b1, 6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0, wd(0,1,0,0,0,2,0,1,1,0,4), 4'b0000);
    cyc(1'b1, 6'd0, 6'd32, 5'd4, 5'd2, 5'd5, 1'b0, z, 4'b1000);
    cyc(1'b1, 6'd0, 6'd32, 5'd4, 5'd2, 5'd5, 1'b0, wd(1,0,0,0,0,2,0,0,1,1,5), 4'b0000);
    idle(3);
    // lw to r0 never stalls; rt match also stalls
    cyc(1'b1, 6'd35, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0, wd(0,1,0,0,0,2,0,1,0,0,0), 4'b0000);
    cyc(1'b1, 6'd0, 6'd32, 5'd0, 5'd0, 5'd6, 1'b0, wd(1,0,0,0,0,2,0,0,1,1,6), 4'b0000);
    cyc(1'b1, 6'd35, 6'd0, 5'd1, 5'd7, 5'd0, 1'b0, wd(0,1,0,0,0,2,0,1,1,0,7), 4'b0000);
    cyc(1'b1, 6'd43, 6'd0, 5'd1, 5'd7, 5'd0, 1'b0, z, 4'b1000);
    cyc(1'b1, 6'd43, 6'd0, 5'd1, 5'd7, 5'd0, 1'b0, wd(0,1,0,0,0,2,1,0,0,0,7), 4'b0000);
    idle(3);
    // taken beq squashes the jump in ID; bne with br_taken=1 does not flush
    cyc(1'b1, 6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0, wd(0,0,1,0,0,6,0,0,0,0,2), 4'b0000);
    cyc(1'b1, 6'd2, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1, z, 4'b0110);
    cyc(1'b1, 6'd5, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0, wd(0,0,1,1,0,6,0,0,0,0,2), 4'b0000);
    cyc(1'b1, 6'd8, 6'd0, 5'd1, 5'd6, 5'd0, 1'b1, wd(0,1,0,0,0,2,0,0,1,1,6), 4'b0000);
    // invalid ID slot: no illegal, no jump flush
    cyc(1'b0, 6'd63, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0, z, 4'b0000);
    cyc(1'b0, 6'd2, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, z, 4'b0000);
    idle(3);
    // reset while a stall is pending
    cyc(1'b1, 6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0, wd(0,1,0,0,0,2,0,1,1,0,4), 4'b0000);
    id_valid = 1'b1; op_code = 6'd0; func = 6'd32; rs = 5'd4; rt = 5'd2; rd = 5'd5;
    do_reset();
    cyc(1'b1, 6'd0, 6'd32, 5'd4, 5'd2, 5'd5, 1'b0, wd(1,0,0,0,0,2,0,0,1,1,5), 4'b0000);
    idle(3);
    // reset while a bne flush is pending
    cyc(1'b1, 6'd5, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0, wd(0,0,1,1,0,6,0,0,0,0,2), 4'b0000);
    id_valid = 1'b0; br_taken = 1'b0;
    do_reset();
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
